// File: rtl/wfifo_level.sv
// wfifo_level: write-side FIFO occupancy with hysteresis throttle flag.
// Optional sticky pointer-integrity error built when WLEVEL_ERR_CHECK_EN is defined.
module wfifo_level #(
   parameter int ADDRSIZE = 4,
   parameter int AFULL_HI = 12,
   parameter int AFULL_LO = 8
) (
   input  logic                wclk,
   input  logic                wrst_n,
   input  logic [ADDRSIZE:0]   rptr,
   input  logic [ADDRSIZE:0]   wptr,
   output logic [ADDRSIZE:0]   wq2_rptr,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                walmost_full,
   output logic                werr
);
   localparam logic [ADDRSIZE:0] HI   = AFULL_HI[ADDRSIZE:0];
   localparam logic [ADDRSIZE:0] LO   = AFULL_LO[ADDRSIZE:0];
   localparam logic [ADDRSIZE:0] FULL = {1'b1, {ADDRSIZE{1'b0}}};
   typedef enum logic {OPEN, THROTTLE} state_t;
   state_t state, state_nx;
   logic [ADDRSIZE:0] wq1, rbin, wbin;
   // Binary bit i is the XOR of all Gray bits at or above i.
   function automatic logic [ADDRSIZE:0] g2b(input logic [ADDRSIZE:0] g);
      for (int i = 0; i <= ADDRSIZE; i++) g2b[i] = ^(g >> i);
   endfunction
   assign rbin = g2b(wq2_rptr);
   assign wbin = g2b(wptr);
   assign walmost_full = (state == THROTTLE);
   always_comb begin
      state_nx = state;
      state_nx = (state == OPEN) ? ((wlevel >= HI) ? THROTTLE : OPEN)
                                 : ((wlevel <= LO) ? OPEN : THROTTLE);
   end
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wq1      <= '0;
         wq2_rptr <= '0;
         wlevel   <= '0;
         state    <= OPEN;
      end else begin
         wq1      <= rptr;
         wq2_rptr <= wq1;
         wlevel   <= wbin - rbin;
         state    <= state_nx;
      end
   end
`ifdef WLEVEL_ERR_CHECK_EN
   localparam logic [ADDRSIZE:0] ONE = {{ADDRSIZE{1'b0}}, 1'b1};
   logic [ADDRSIZE:0] wq2_prev, rdiff;
   // More than one bit set means a non-Gray step crossed the synchroniser.
   assign rdiff = wq2_rptr ^ wq2_prev;
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wq2_prev <= '0;
         werr     <= 1'b0;
      end else begin
         wq2_prev <= wq2_rptr;
         werr     <= werr | (|(rdiff & (rdiff - ONE))) | (wlevel > FULL);
      end
   end
`else
   assign werr = 1'b0;
`endif
endmodule

// File: tb/tb_wfifo_level.sv
// tb_wfifo_level: directed checks of level, latency, hysteresis, wrap, full and error flag.
module tb_wfifo_level;
   logic       wclk, wrst_n, walmost_full, werr;
   logic [4:0] rptr, wptr, wq2_rptr, wlevel;
   int checks = 0, errors = 0;
`ifdef WLEVEL_ERR_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   wfifo_level #(.ADDRSIZE(4), .AFULL_HI(12), .AFULL_LO(8)) dut (
      .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .wptr(wptr),
      .wq2_rptr(wq2_rptr), .wlevel(wlevel), .walmost_full(walmost_full), .werr(werr)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   function automatic logic [4:0] gray(input int n);
      logic [4:0] b;
      b = n[4:0];
      return b ^ (b >> 1);
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge wclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      wrst_n = 1'b0;
      rptr = 5'b10101;
      wptr = 5'b00110;
      step(1);
      chk("rst_wq2", wq2_rptr, 0);
      chk("rst_level", wlevel, 0);
      chk("rst_af", walmost_full, 0);
      chk("rst_err", werr, 0);
      step(2);
      chk("rst_wq2_hold", wq2_rptr, 0);
      chk("rst_level_hold", wlevel, 0);
      chk("rst_af_hold", walmost_full, 0);
      chk("rst_err_hold", werr, 0);
      // threshold and latency
      rptr = 5'b00000;
      wptr = 5'b01110;
      wrst_n = 1'b1;
      step(2);
      chk("lvl11", wlevel, 11);
      chk("af_lvl11", walmost_full, 0);
      wptr = 5'b01010;
      step(1);
      chk("lvl12", wlevel, 12);
      chk("af_lag", walmost_full, 0);
      step(1);
      chk("af_set", walmost_full, 1);
      // hysteresis
      wptr = gray(9);
      step(1);
      chk("lvl9", wlevel, 9);
      step(1);
      chk("af_hold9", walmost_full, 1);
      wptr = gray(8);
      step(1);
      chk("lvl8", wlevel, 8);
      chk("af_lag8", walmost_full, 1);
      step(1);
      chk("af_clr8", walmost_full, 0);
      wptr = gray(11);
      step(1);
      chk("lvl11b", wlevel, 11);
      step(1);
      chk("af_open11", walmost_full, 0);
      // wrap
      wptr = 5'b00011;
      rptr = 5'b10010;
      step(1);
      chk("wrap_wq2_lag", wq2_rptr, 0);
      step(1);
      chk("wrap_wq2", wq2_rptr, 5'b10010);
      chk("wrap_lvl_lag", wlevel, 2);
      step(1);
      chk("wrap_lvl", wlevel, 6);
      step(1);
      chk("wrap_af", walmost_full, 0);
      // full, then drain via read pointer
      wptr = 5'b11000;
      rptr = 5'b00000;
      step(3);
      chk("full_lvl", wlevel, 16);
      step(1);
      chk("full_af", walmost_full, 1);
      for (int i = 1; i <= 8; i++) begin
         rptr = gray(i);
         step(1);
         chk($sformatf("drain_lvl_%0d", i), wlevel, (i <= 2) ? 16 : 18 - i);
         chk($sformatf("drain_af_%0d", i), walmost_full, 1);
      end
      step(1);
      chk("drain_lvl9", wlevel, 9);
      step(1);
      chk("drain_lvl8", wlevel, 8);
      chk("drain_af_lag", walmost_full, 1);
      step(1);
      chk("drain_af_clr", walmost_full, 0);
      // simultaneous pointer moves give a single combined update
      wptr = gray(12);
      rptr = gray(9);
      step(1);
      chk("simul_w_only", wlevel, 4);
      step(2);
      chk("simul_both", wlevel, 3);
      // asynchronous reset mid-cycle
      #2;
      wrst_n = 1'b0;
      #1;
      chk("async_level", wlevel, 0);
      chk("async_wq2", wq2_rptr, 0);
      chk("async_af", walmost_full, 0);
      rptr = 5'b00000;
      wptr = 5'b00000;
      step(1);
      wrst_n = 1'b1;
      step(1);
      // error: multi-bit read pointer jump
      rptr = 5'b00011;
      step(2);
      chk("err_lag", werr, 0);
      step(1);
      chk("err_jump", werr, ERR_EXP);
      step(3);
      chk("err_sticky", werr, ERR_EXP);
      wrst_n = 1'b0;
      #1;
      chk("err_rst", werr, 0);
      rptr = 5'b00000;
      wptr = gray(17);
      step(1);
      wrst_n = 1'b1;
      step(1);
      chk("lvl17", wlevel, 17);
      step(1);
      chk("err_over", werr, ERR_EXP);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
